operand_issuer: RTL and testbench

Upstream feeder for the registered two-operand adder stage. Accepts operand pairs over a valid/ready handshake, buffers them in a small FIFO, and issues them to the adder as single-cycle `start` pulses with `a`/`b` held stable. It enforces a minimum spacing between issues so each result is produced before the next pair arrives. It also reports occupancy, activity and a wrapping issue count.

---
 rtl/operand_issuer.sv | 122 ++++++++++++
 tb/tb_operand_issuer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issuer.sv
// rtl/operand_issuer.sv - FIFO-buffered operand pair issuer with spaced start pulses
module operand_issuer #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  output logic                       start,
  output logic [W-1:0]               a,
  output logic [W-1:0]               b,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 issued_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  logic [2*W-1:0] mem_q [DEPTH];

  state_t         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           start_q, start_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           push, pop;

  // Ready is a pure decode of the occupancy so a full FIFO never accepts on a pop edge.
  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ST_IDLE) && (level_q != '0);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    gap_d    = gap_q;
    a_d      = a_q;
    b_d      = b_q;
    start_d  = 1'b0;
    cnt_d    = cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          {a_d, b_d} = mem_q[rd_ptr_q];
          cnt_d      = cnt_q + 8'd1;
          start_d    = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gap_d   = GW'(GAP);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      gap_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      gap_q    <= gap_d;
      a_q      <= a_d;
      b_q      <= b_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  assign start      = start_q;
  assign a          = a_q;
  assign b          = b_q;
  assign level      = level_q;
  assign issued_cnt = cnt_q;
  assign busy       = (level_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_operand_issuer.sv
// tb/tb_operand_issuer.sv - directed self-checking bench for operand_issuer
module tb_operand_issuer;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic [2:0]   level;
  logic [7:0]   issued_cnt;

  operand_issuer #(.W(W), .DEPTH(4), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start(start), .a(a), .b(b), .busy(busy),
    .level(level), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_pulse = 0;
  int pulse_cyc[$];
  logic [2*W-1:0] exp_q[$];
  logic [7:0] model_cnt = 8'd0;
  bit track = 0;
  int max_level = 0;
  int rdy_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of accepted pairs, in acceptance order.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back({in_a, in_b});
  end

  always @(negedge clk) begin
    if (rst_n && start) begin
      logic [2*W-1:0] e;
      if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("a_order", a, e[2*W-1:W]);
        chk("b_order", b, e[W-1:0]);
      end
      model_cnt = model_cnt + 8'd1;
      chk("issued_cnt_pulse", issued_cnt, model_cnt);
      pulse_cyc.push_back(cyc);
      n_pulse++;
    end
    if (rst_n && track) begin
      if (int'(level) > max_level) max_level = int'(level);
      if (in_ready != (level != 3'd4)) rdy_bad++;
    end
  end

  task automatic wait_drain(input string tag);
    int g = 0;
    @(negedge clk);
    while (busy && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk({tag, "_drain_timeout"}, 1, 0);
  endtask

  task automatic feed(input int n, input int base);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < n * 8 + 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = W'(12'h100 + base + i);
      in_b = W'(12'h800 + base + i);
      acc = in_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (i < n) chk("feed_timeout", i, n);
  endtask

  initial begin
    int saved;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_cnt", issued_cnt, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pair: accepted at edge k, start between k+1 and k+2
    in_valid = 1'b1; in_a = 12'h123; in_b = 12'h456;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("single_no_start_k", start, 0);
    chk("single_level_k", level, 1);
    @(negedge clk);
    chk("single_start", start, 1);
    chk("single_a", a, 12'h123);
    chk("single_b", b, 12'h456);
    chk("single_cnt", issued_cnt, 1);
    @(negedge clk);
    chk("single_start_low", start, 0);
    chk("single_a_hold", a, 12'h123);
    @(negedge clk);
    chk("single_busy_wait", busy, 1);
    @(negedge clk);
    chk("single_busy_done", busy, 0);
    chk("single_a_final", a, 12'h123);
    chk("single_b_final", b, 12'h456);
    chk("single_cnt_final", issued_cnt, 1);

    // Fill and drain: six pairs, FIFO hits full, pulses 4 cycles apart
    pulse_cyc.delete();
    max_level = 0; rdy_bad = 0; track = 1;
    feed(6, 0);
    wait_drain("fill");
    track = 0;
    chk("fill_pulses", pulse_cyc.size(), 6);
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk("fill_spacing", pulse_cyc[i] - pulse_cyc[i-1], 4);
    chk("fill_max_level", max_level, 4);
    chk("fill_ready_decode", rdy_bad, 0);
    chk("fill_leftover", exp_q.size(), 0);
    chk("fill_cnt", issued_cnt, 7);

    // Simultaneous push/pop with level 2
    @(negedge clk);
    in_valid = 1'b1; in_a = 12'hA00; in_b = 12'hB00;
    @(posedge clk); @(negedge clk);
    in_a = 12'hA01; in_b = 12'hB01;
    @(posedge clk); @(negedge clk);
    in_a = 12'hA02; in_b = 12'hB02;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("pp_level_before", level, 2);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b1; in_a = 12'hA03; in_b = 12'hB03;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("pp_level_after", level, 2);
    chk("pp_start", start, 1);
    chk("pp_head_a", a, 12'hA01);
    chk("pp_head_b", b, 12'hB01);
    wait_drain("pp");
    chk("pp_cnt", issued_cnt, 11);

    // Counter wrap: 244 more issues reach 255, then 0, then 1
    feed(244, 16);
    wait_drain("wrap");
    chk("wrap_255", issued_cnt, 255);
    feed(1, 3);
    wait_drain("wrap0");
    chk("wrap_0", issued_cnt, 0);
    feed(1, 4);
    wait_drain("wrap1");
    chk("wrap_1", issued_cnt, 1);

    // Mid-operation reset during WAIT with three pairs buffered
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = W'(12'hC00 + i); in_b = W'(12'hD00 + i);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_level", level, 3);
    chk("mid_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt = 8'd0;
    #1;
    chk("mid_start", start, 0);
    chk("mid_a", a, 0);
    chk("mid_b", b, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_level_rst", level, 0);
    chk("mid_cnt", issued_cnt, 0);
    chk("mid_busy_rst", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saved = n_pulse;
    repeat (10) @(negedge clk);
    chk("mid_no_start", n_pulse - saved, 0);
    chk("mid_idle_busy", busy, 0);
    feed(1, 7);
    wait_drain("mid");
    chk("mid_new_issue", n_pulse - saved, 1);
    chk("mid_new_cnt", issued_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
